full_subtractor: RTL and testbench

FULL_SUBTRACTOR -- requirements
Module: full_subtractor

---
 rtl/full_subtractor_pkg.sv | 12 +
 rtl/full_subtractor_if.sv | 27 ++
 rtl/full_subtractor_cell.sv | 14 +
 rtl/full_subtractor.sv | 72 +++++++
 tb/tb_full_subtractor.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/full_subtractor_pkg.sv
// Shared constants and helpers for the full_subtractor block.
package full_subtractor_pkg;

  localparam int unsigned WIDTH_DEFAULT = 1;
  localparam int unsigned WIDTH_MAX     = 64;

  // Two's-complement overflow of a - b, judged from the operand and result MSBs.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb ^ b_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/full_subtractor_if.sv
// Operand/result bundle for full_subtractor; master drives operands, slave returns the result.
interface full_subtractor_if
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Bin;
  logic             in_valid;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             out_valid;
  logic             ovf;

  modport master (
    output a, b, Bin, in_valid,
    input  D, Bout, out_valid, ovf
  );

  modport slave (
    input  a, b, Bin, in_valid,
    output D, Bout, out_valid, ovf
  );

endinterface

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: difference and borrow-out from x - y - bi.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Borrow propagates when x == y, is generated when x=0 and y=1.
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/full_subtractor.sv
// WIDTH-bit ripple-borrow subtractor: {Bout, D} = a - b - Bin, plus signed overflow.
// Define FULL_SUBTRACTOR_REG_OUT_EN for registered outputs (1-cycle latency);
// otherwise the outputs are purely combinational and clk/rst_n are ignored.
module full_subtractor
  import full_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  input  logic             in_valid,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH:0]   br;
  logic [WIDTH-1:0] diff_c;
  logic             ovf_c;

  assign br[0] = Bin;

  // Ripple borrow chain, one cell per bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_subtractor_cell u_cell (
      .x  (a[i]),
      .y  (b[i]),
      .bi (br[i]),
      .d  (diff_c[i]),
      .bo (br[i+1])
    );
  end

  assign ovf_c = sub_ovf(a[WIDTH-1], b[WIDTH-1], diff_c[WIDTH-1]);

`ifdef FULL_SUBTRACTOR_REG_OUT_EN

  // Capture on valid; hold results and drop out_valid otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D         <= '0;
      Bout      <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      D         <= diff_c;
      Bout      <= br[WIDTH];
      ovf       <= ovf_c;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`else

  // Zero-latency outputs; clk and rst_n have no role in this build.
  assign D         = diff_c;
  assign Bout      = br[WIDTH];
  assign ovf       = ovf_c;
  assign out_valid = in_valid;

  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst_n};

`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Directed and random checks of full_subtractor at WIDTH 1, 8 and 16, either build mode.
module tb_full_subtractor;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  full_subtractor_if #(.WIDTH(1))  bus1 ();
  full_subtractor_if #(.WIDTH(8))  bus8 ();
  full_subtractor_if #(.WIDTH(16)) bus16 ();

  full_subtractor #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(bus1.a), .b(bus1.b), .Bin(bus1.Bin),
    .D(bus1.D), .Bout(bus1.Bout), .in_valid(bus1.in_valid),
    .out_valid(bus1.out_valid), .ovf(bus1.ovf)
  );

  full_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .a(bus8.a), .b(bus8.b), .Bin(bus8.Bin),
    .D(bus8.D), .Bout(bus8.Bout), .in_valid(bus8.in_valid),
    .out_valid(bus8.out_valid), .ovf(bus8.ovf)
  );

  full_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .a(bus16.a), .b(bus16.b), .Bin(bus16.Bin),
    .D(bus16.D), .Bout(bus16.Bout), .in_valid(bus16.in_valid),
    .out_valid(bus16.out_valid), .ovf(bus16.ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Let one vector take effect: a capture edge when registered, a settle delay otherwise.
  task automatic step();
`ifdef FULL_SUBTRACTOR_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus1.in_valid = 1'b1; bus1.a = 1'b0; bus1.b = 1'b0; bus1.Bin = 1'b0;
    bus16.in_valid = 1'b1; bus16.a = '0; bus16.b = '0; bus16.Bin = 1'b0;
    bus8.in_valid = 1'b1;
    bus8.a = 8'h33; bus8.b = 8'h11; bus8.Bin = 1'b0;
    #1;
`ifdef FULL_SUBTRACTOR_REG_OUT_EN
    n_checks++;
    if (bus8.D !== 8'h00) begin n_fail++; $display("FAIL reset_D got %h want 00", bus8.D); end
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus8.out_valid); end
`else
    n_checks++;
    if (bus8.D !== 8'h22) begin n_fail++; $display("FAIL reset_D got %h want 22", bus8.D); end
    n_checks++;
    if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_out_valid got %b want 1", bus8.out_valid); end
`endif
    n_checks++;
    if (bus8.Bout !== 1'b0) begin n_fail++; $display("FAIL reset_Bout got %b want 0", bus8.Bout); end
    n_checks++;
    if (bus8.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus8.ovf); end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_w1_exhaustive();
    // Index {a,b,Bin}; entries {D,Bout} and ovf computed by hand.
    logic [1:0] exp_db [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic       exp_ov [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] v;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      bus1.a = v[2]; bus1.b = v[1]; bus1.Bin = v[0];
      step();
      n_checks++;
      if ({bus1.D, bus1.Bout} !== exp_db[i]) begin
        n_fail++;
        $display("FAIL w1_DBout[%0d] got %b%b want %b", i, bus1.D, bus1.Bout, exp_db[i]);
      end
      n_checks++;
      if (bus1.ovf !== exp_ov[i]) begin
        n_fail++;
        $display("FAIL w1_ovf[%0d] got %b want %b", i, bus1.ovf, exp_ov[i]);
      end
    end
  endtask

  task automatic test_w8_directed();
    logic [7:0] va [8] = '{8'h00, 8'h05, 8'h80, 8'h7F, 8'h00, 8'h5A, 8'h10, 8'hFF};
    logic [7:0] vb [8] = '{8'h01, 8'h03, 8'h01, 8'hFF, 8'hFF, 8'h5A, 8'h20, 8'h00};
    logic       vc [8] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};
    logic [7:0] ed [8] = '{8'hFF, 8'h01, 8'h7F, 8'h80, 8'h00, 8'h00, 8'hF0, 8'hFE};
    logic       eb [8] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
    logic       eo [8] = '{1'b0,  1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0};
    for (int i = 0; i < 8; i++) begin
      bus8.a = va[i]; bus8.b = vb[i]; bus8.Bin = vc[i];
      step();
      n_checks++;
      if (bus8.D !== ed[i]) begin n_fail++; $display("FAIL w8_D[%0d] got %h want %h", i, bus8.D, ed[i]); end
      n_checks++;
      if (bus8.Bout !== eb[i]) begin n_fail++; $display("FAIL w8_Bout[%0d] got %b want %b", i, bus8.Bout, eb[i]); end
      n_checks++;
      if (bus8.ovf !== eo[i]) begin n_fail++; $display("FAIL w8_ovf[%0d] got %b want %b", i, bus8.ovf, eo[i]); end
      n_checks++;
      if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL w8_out_valid[%0d] got %b want 1", i, bus8.out_valid); end
    end
  endtask

  task automatic test_boundary_w16();
    bus16.a = 16'h0000; bus16.b = 16'hFFFF; bus16.Bin = 1'b1;
    step();
    n_checks++;
    if ({bus16.Bout, bus16.D} !== 17'h1_0000) begin
      n_fail++; $display("FAIL w16_zero_minus_ones got %b_%h want 1_0000", bus16.Bout, bus16.D);
    end
    bus16.a = 16'hBEEF; bus16.b = 16'hBEEF; bus16.Bin = 1'b0;
    step();
    n_checks++;
    if ({bus16.Bout, bus16.D} !== 17'h0_0000) begin
      n_fail++; $display("FAIL w16_equal got %b_%h want 0_0000", bus16.Bout, bus16.D);
    end
  endtask

`ifdef FULL_SUBTRACTOR_REG_OUT_EN
  task automatic test_valid();
    bus8.in_valid = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.Bin = 1'b0;
    step();
    n_checks++;
    if ({bus8.out_valid, bus8.Bout, bus8.D} !== 10'b11_1111_0000) begin
      n_fail++; $display("FAIL reg_capture got v=%b bo=%b D=%h want v=1 bo=1 D=f0", bus8.out_valid, bus8.Bout, bus8.D);
    end
    bus8.in_valid = 1'b0; bus8.a = 8'h55; bus8.b = 8'h11;
    step();
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL reg_valid_drop got %b want 0", bus8.out_valid); end
    n_checks++;
    if (bus8.D !== 8'hF0) begin n_fail++; $display("FAIL reg_hold_D got %h want f0", bus8.D); end
    n_checks++;
    if (bus8.Bout !== 1'b1) begin n_fail++; $display("FAIL reg_hold_Bout got %b want 1", bus8.Bout); end
  endtask

  task automatic test_reset_mid();
    bus8.in_valid = 1'b1; bus8.a = 8'h80; bus8.b = 8'h01; bus8.Bin = 1'b0;
    step();
    bus8.a = 8'h40; bus8.b = 8'h01;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D} !== 11'h000) begin
      n_fail++; $display("FAIL async_reset got v=%b ovf=%b bo=%b D=%h want all 0", bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D);
    end
    rst_n = 1'b1;
    bus8.in_valid = 1'b0;
    step();
    n_checks++;
    if ({bus8.out_valid, bus8.D} !== 9'h000) begin
      n_fail++; $display("FAIL post_reset_idle got v=%b D=%h want 0 00", bus8.out_valid, bus8.D);
    end
    bus8.in_valid = 1'b1;
    step();
    n_checks++;
    if ({bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D} !== 11'h43F) begin
      n_fail++; $display("FAIL first_capture got v=%b ovf=%b bo=%b D=%h want 1 0 0 3f", bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D);
    end
  endtask
`else
  task automatic test_valid();
    bus8.in_valid = 1'b0; bus8.a = 8'h10; bus8.b = 8'h20; bus8.Bin = 1'b0;
    step();
    n_checks++;
    if (bus8.out_valid !== 1'b0) begin n_fail++; $display("FAIL comb_valid_low got %b want 0", bus8.out_valid); end
    n_checks++;
    if ({bus8.Bout, bus8.D} !== 9'h1F0) begin
      n_fail++; $display("FAIL comb_no_valid_D got %b_%h want 1_f0", bus8.Bout, bus8.D);
    end
    bus8.in_valid = 1'b1;
    step();
    n_checks++;
    if (bus8.out_valid !== 1'b1) begin n_fail++; $display("FAIL comb_valid_high got %b want 1", bus8.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus8.a = 8'h40; bus8.b = 8'h01; bus8.Bin = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D} !== 11'h43F) begin
      n_fail++; $display("FAIL comb_reset_ignored got v=%b ovf=%b bo=%b D=%h want 1 0 0 3f", bus8.out_valid, bus8.ovf, bus8.Bout, bus8.D);
    end
    rst_n = 1'b1;
    #1;
  endtask
`endif

  task automatic test_random_w16();
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [16:0] exp_full;
    logic        exp_ovf;
    bus16.in_valid = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      bus16.a = ra; bus16.b = rb; bus16.Bin = rc;
      step();
      exp_full = {1'b0, ra} - {1'b0, rb} - 17'(rc);
      exp_ovf  = (ra[15] != rb[15]) && (exp_full[15] != ra[15]);
      n_checks++;
      if ({bus16.Bout, bus16.D} !== exp_full) begin
        n_fail++;
        $display("FAIL rand_diff[%0d] a=%h b=%h bin=%b got %h want %h", i, ra, rb, rc, {bus16.Bout, bus16.D}, exp_full);
      end
      n_checks++;
      if (bus16.ovf !== exp_ovf) begin
        n_fail++;
        $display("FAIL rand_ovf[%0d] a=%h b=%h bin=%b got %b want %b", i, ra, rb, rc, bus16.ovf, exp_ovf);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_w1_exhaustive();
    test_w8_directed();
    test_boundary_w16();
    test_valid();
    test_reset_mid();
    test_random_w16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
